// File: rtl/toy_bus_pkg.sv
// ToyBusReq field widths, flattened payload width and pack/unpack helpers.
package toy_bus_pkg;

  localparam int ADDR_W    = 32;
  localparam int STRB_W    = 32;
  localparam int DATA_W    = 256;
  localparam int SRCID_W   = 4;
  localparam int TGTID_W   = 4;
  localparam int SB_W      = 32;
  localparam int REQ_PLD_W = ADDR_W + STRB_W + DATA_W + 1 + SRCID_W + TGTID_W + SB_W;

  localparam int REQ_FIFO_DEPTH = 2;

  typedef struct packed {
    logic [ADDR_W-1:0]  addr;
    logic [STRB_W-1:0]  strb;
    logic [DATA_W-1:0]  data;
    logic               opcode;
    logic [SRCID_W-1:0] src_id;
    logic [TGTID_W-1:0] tgt_id;
    logic [SB_W-1:0]    sideband;
  } req_t;

  function automatic logic [REQ_PLD_W-1:0] req_pack(input req_t r);
    return {r.addr, r.strb, r.data, r.opcode, r.src_id, r.tgt_id, r.sideband};
  endfunction

  function automatic req_t req_unpack(input logic [REQ_PLD_W-1:0] p);
    req_t r;
    {r.addr, r.strb, r.data, r.opcode, r.src_id, r.tgt_id, r.sideband} = p;
    return r;
  endfunction

endpackage

// File: rtl/toy_bus_rr_hold_arb.sv
// 3-way round-robin arbiter with a bounded same-requester hold.
module toy_bus_rr_hold_arb
  import toy_bus_pkg::*;
#(
  parameter int MAX_HOLD = 2
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [2:0] vld_i,
  input  logic       space_i,
  output logic [2:0] gnt_o,
  output logic [1:0] win_o,
  output logic       acc_o
);

  localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD - 1);

  logic [1:0]    last_q, last_d;
  logic [HW-1:0] hold_q, hold_d;
  // The reset value of last_grant is only a rotation pointer (so in0 wins
  // first); the hold rule must not extend a grant that never happened.
  logic          started_q, started_d;
  logic          keep;
  logic [1:0]    win;
  logic          acc;

  function automatic logic [1:0] rr_add(input logic [1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= 3) s = s - 3;
    if (s >= 3) s = s - 3;
    return 2'(s);
  endfunction

  // Grant selection and next-state for the hold tracking.
  always_comb begin
    keep = started_q && vld_i[last_q] && (hold_q < HOLD_MAX);
    win  = last_q;
    if (!keep) begin
      for (int i = 3; i >= 1; i--) begin
        if (vld_i[rr_add(last_q, i)]) win = rr_add(last_q, i);
      end
    end
    acc       = space_i && (|vld_i) && !rst_i;
    last_d    = last_q;
    hold_d    = hold_q;
    started_d = started_q;
    if (acc) begin
      started_d = 1'b1;
      if (started_q && (win == last_q)) begin
        if (hold_q < HOLD_MAX) hold_d = hold_q + HW'(1);
      end else begin
        hold_d = '0;
        last_d = win;
      end
    end
  end

  // Arbitration state registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      last_q    <= 2'd2;
      hold_q    <= '0;
      started_q <= 1'b0;
    end else begin
      last_q    <= last_d;
      hold_q    <= hold_d;
      started_q <= started_d;
    end
  end

  assign win_o = win;
  assign acc_o = acc;
  assign gnt_o = acc ? (3'b001 << win) : 3'b000;

endmodule

// File: rtl/toy_bus_arb_node_rr_req.sv
// ToyBusReq 3:1 merge node: hold-bounded round-robin into a 2-entry output FIFO.
module toy_bus_arb_node_rr_req
  import toy_bus_pkg::*;
#(
  parameter int MAX_HOLD   = 2,
  parameter int FIFO_DEPTH = REQ_FIFO_DEPTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in0_vld,
  output logic                 in0_rdy,
  input  logic [ADDR_W-1:0]    in0_addr,
  input  logic [STRB_W-1:0]    in0_strb,
  input  logic [DATA_W-1:0]    in0_data,
  input  logic                 in0_opcode,
  input  logic [SRCID_W-1:0]   in0_src_id,
  input  logic [TGTID_W-1:0]   in0_tgt_id,
  input  logic [SB_W-1:0]      in0_sideband,
  input  logic                 in1_vld,
  output logic                 in1_rdy,
  input  logic [ADDR_W-1:0]    in1_addr,
  input  logic [STRB_W-1:0]    in1_strb,
  input  logic [DATA_W-1:0]    in1_data,
  input  logic                 in1_opcode,
  input  logic [SRCID_W-1:0]   in1_src_id,
  input  logic [TGTID_W-1:0]   in1_tgt_id,
  input  logic [SB_W-1:0]      in1_sideband,
  input  logic                 in2_vld,
  output logic                 in2_rdy,
  input  logic [ADDR_W-1:0]    in2_addr,
  input  logic [STRB_W-1:0]    in2_strb,
  input  logic [DATA_W-1:0]    in2_data,
  input  logic                 in2_opcode,
  input  logic [SRCID_W-1:0]   in2_src_id,
  input  logic [TGTID_W-1:0]   in2_tgt_id,
  input  logic [SB_W-1:0]      in2_sideband,
  output logic                 out0_vld,
  input  logic                 out0_rdy,
  output logic [ADDR_W-1:0]    out0_addr,
  output logic [STRB_W-1:0]    out0_strb,
  output logic [DATA_W-1:0]    out0_data,
  output logic                 out0_opcode,
  output logic [SRCID_W-1:0]   out0_src_id,
  output logic [TGTID_W-1:0]   out0_tgt_id,
  output logic [SB_W-1:0]      out0_sideband
);

  req_t                 in_req [3];
  logic [REQ_PLD_W-1:0] win_pld;
  logic [REQ_PLD_W-1:0] mem_q [2];
  logic                 wr_q, wr_d, rd_q, rd_d;
  logic [1:0]           count_q, count_d;
  logic                 space, push, pop;
  logic [2:0]           gnt;
  logic [1:0]           win;
  req_t                 head;

  assign in_req[0] = '{in0_addr, in0_strb, in0_data, in0_opcode, in0_src_id, in0_tgt_id, in0_sideband};
  assign in_req[1] = '{in1_addr, in1_strb, in1_data, in1_opcode, in1_src_id, in1_tgt_id, in1_sideband};
  assign in_req[2] = '{in2_addr, in2_strb, in2_data, in2_opcode, in2_src_id, in2_tgt_id, in2_sideband};

  // Space is judged on registered count only, so a pop never enables a same-cycle push.
  assign space = int'(count_q) < FIFO_DEPTH;

  toy_bus_rr_hold_arb #(.MAX_HOLD(MAX_HOLD)) u_arb (
    .clk_i   (clk),
    .rst_i   (rst),
    .vld_i   ({in2_vld, in1_vld, in0_vld}),
    .space_i (space),
    .gnt_o   (gnt),
    .win_o   (win),
    .acc_o   (push)
  );

  assign in0_rdy = gnt[0];
  assign in1_rdy = gnt[1];
  assign in2_rdy = gnt[2];

  // Winner payload mux.
  always_comb begin
    win_pld = req_pack(in_req[0]);
    case (win)
      2'd1:    win_pld = req_pack(in_req[1]);
      2'd2:    win_pld = req_pack(in_req[2]);
      default: ;
    endcase
  end

  // FIFO pointer and occupancy next-state.
  always_comb begin
    pop  = (count_q != 2'd0) && out0_rdy;
    wr_d = wr_q ^ push;
    rd_d = rd_q ^ pop;
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // FIFO control registers; reset discards any buffered beats.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q    <= 1'b0;
      rd_q    <= 1'b0;
      count_q <= 2'd0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
    end
  end

  // FIFO storage; contents are don't-care while the entry is empty.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= win_pld;
  end

  assign head          = req_unpack(mem_q[rd_q]);
  assign out0_vld      = count_q != 2'd0;
  assign out0_addr     = head.addr;
  assign out0_strb     = head.strb;
  assign out0_data     = head.data;
  assign out0_opcode   = head.opcode;
  assign out0_src_id   = head.src_id;
  assign out0_tgt_id   = head.tgt_id;
  assign out0_sideband = head.sideband;

endmodule

// File: tb/tb_toy_bus_arb_node_rr_req.sv
// Self-checking bench: two DUTs (MAX_HOLD=2 and MAX_HOLD=1) on shared stimulus,
// checked every cycle against a queue-based behavioural model.
module tb_toy_bus_arb_node_rr_req;
  import toy_bus_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] vld;
  logic       ordy;
  req_t       rq [3];

  logic [REQ_PLD_W-1:0] opld [2];
  logic                 ovld [2];
  logic [2:0]           irdy [2];

  always #5 clk = ~clk;

  for (genvar k = 0; k < 2; k++) begin : g_dut
    localparam int MH = (k == 0) ? 2 : 1;
    logic [31:0]  a, s, sb;
    logic [255:0] d;
    logic         op, v;
    logic [3:0]   si, ti;
    logic [2:0]   r;
    toy_bus_arb_node_rr_req #(.MAX_HOLD(MH)) u_dut (
      .clk(clk), .rst(rst),
      .in0_vld(vld[0]), .in0_rdy(r[0]), .in0_addr(rq[0].addr), .in0_strb(rq[0].strb),
      .in0_data(rq[0].data), .in0_opcode(rq[0].opcode), .in0_src_id(rq[0].src_id),
      .in0_tgt_id(rq[0].tgt_id), .in0_sideband(rq[0].sideband),
      .in1_vld(vld[1]), .in1_rdy(r[1]), .in1_addr(rq[1].addr), .in1_strb(rq[1].strb),
      .in1_data(rq[1].data), .in1_opcode(rq[1].opcode), .in1_src_id(rq[1].src_id),
      .in1_tgt_id(rq[1].tgt_id), .in1_sideband(rq[1].sideband),
      .in2_vld(vld[2]), .in2_rdy(r[2]), .in2_addr(rq[2].addr), .in2_strb(rq[2].strb),
      .in2_data(rq[2].data), .in2_opcode(rq[2].opcode), .in2_src_id(rq[2].src_id),
      .in2_tgt_id(rq[2].tgt_id), .in2_sideband(rq[2].sideband),
      .out0_vld(v), .out0_rdy(ordy), .out0_addr(a), .out0_strb(s), .out0_data(d),
      .out0_opcode(op), .out0_src_id(si), .out0_tgt_id(ti), .out0_sideband(sb)
    );
    assign opld[k] = {a, s, d, op, si, ti, sb};
    assign ovld[k] = v;
    assign irdy[k] = r;
  end

  int nvec = 0;
  int nerr = 0;

  // Model: per DUT, the output buffer as a queue, the most recent winner and
  // how many grants in a row it has had (0 = nobody granted since reset).
  logic [REQ_PLD_W-1:0] mq [2][$];
  int mlast [2];
  int mstreak [2];
  int mh [2] = '{2, 1};

  // Values sampled from the DUTs on the most recent step.
  logic [2:0]           s_rdy  [2];
  logic                 s_ovld [2];
  logic [REQ_PLD_W-1:0] s_pld  [2];

  task automatic cmp(input string nm, input int k, input logic [REQ_PLD_W-1:0] act,
                     input logic [REQ_PLD_W-1:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s dut%0d t=%0t act=%0h exp=%0h", nm, k, $time, act, exp);
    end
  endtask

  function automatic int mgrant(input int k, input logic [2:0] v);
    if (v == 3'b000) return -1;
    if (mstreak[k] > 0 && mstreak[k] < mh[k] && v[mlast[k]]) return mlast[k];
    for (int i = 1; i <= 3; i++) begin
      if (v[(mlast[k] + i) % 3]) return (mlast[k] + i) % 3;
    end
    return -1;
  endfunction

  function automatic int oh2i(input logic [2:0] v);
    case (v)
      3'b001:  return 0;
      3'b010:  return 1;
      3'b100:  return 2;
      default: return -1;
    endcase
  endfunction

  task automatic set_pld(input int n, input int tgt);
    rq[n].addr     = $urandom;
    rq[n].strb     = $urandom;
    rq[n].data     = {$urandom, $urandom, $urandom, $urandom,
                      $urandom, $urandom, $urandom, $urandom};
    rq[n].opcode   = 1'($urandom_range(0, 1));
    rq[n].src_id   = 4'(n);
    rq[n].tgt_id   = 4'(tgt);
    rq[n].sideband = $urandom;
  endtask

  // One clock cycle: compare against the model, advance the model, cross the edge.
  task automatic step();
    #1;
    for (int k = 0; k < 2; k++) begin
      int  g;
      bit  space;
      logic [2:0] er;
      g     = mgrant(k, vld);
      space = mq[k].size() < 2;
      er    = 3'b000;
      if (!rst && space && g >= 0) er[g] = 1'b1;
      s_rdy[k]  = irdy[k];
      s_ovld[k] = ovld[k];
      s_pld[k]  = opld[k];
      cmp("rdy", k, REQ_PLD_W'(irdy[k]), REQ_PLD_W'(er));
      cmp("out_vld", k, REQ_PLD_W'(ovld[k]), REQ_PLD_W'(mq[k].size() > 0));
      if (mq[k].size() > 0) cmp("out_pld", k, opld[k], mq[k][0]);
      if (rst) begin
        mq[k].delete();
        mlast[k]   = 2;
        mstreak[k] = 0;
      end else begin
        if (mq[k].size() > 0 && ordy) void'(mq[k].pop_front());
        if (space && g >= 0) begin
          mq[k].push_back(req_pack(rq[g]));
          if (mstreak[k] > 0 && g == mlast[k]) begin
            if (mstreak[k] < mh[k]) mstreak[k]++;
          end else begin
            mlast[k]   = g;
            mstreak[k] = 1;
          end
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  int exp2 [9] = '{0, 0, 1, 1, 2, 2, 0, 0, 1};
  int exp1 [9] = '{0, 1, 2, 0, 1, 2, 0, 1, 2};
  int run1;

  initial begin
    rst  = 1'b1;
    vld  = 3'b000;
    ordy = 1'b1;
    for (int n = 0; n < 3; n++) set_pld(n, n);
    @(negedge clk);
    step();
    do_reset();
    cmp("lit_reset_vld", 0, REQ_PLD_W'(ovld[0]), '0);

    // All three requesting continuously.
    vld = 3'b111;
    for (int i = 0; i < 9; i++) begin
      for (int n = 0; n < 3; n++) set_pld(n, 8 + i);
      step();
      cmp("lit_order_h2", 0, REQ_PLD_W'(oh2i(s_rdy[0])), REQ_PLD_W'(exp2[i]));
      cmp("lit_order_h1", 1, REQ_PLD_W'(oh2i(s_rdy[1])), REQ_PLD_W'(exp1[i]));
      if (i < 2) cmp("lit_latency", 0, REQ_PLD_W'(s_ovld[0]), REQ_PLD_W'(i == 1));
    end

    // Lone requester in1, then in0 joins.
    vld = 3'b000;
    do_reset();
    vld  = 3'b010;
    run1 = 0;
    for (int i = 0; i < 10; i++) begin
      set_pld(1, i);
      step();
      if (oh2i(s_rdy[0]) == 1) run1++;
    end
    cmp("lit_in1_run", 0, REQ_PLD_W'(run1), REQ_PLD_W'(10));
    vld = 3'b011;
    set_pld(0, 1);
    step();
    cmp("lit_in0_after", 0, REQ_PLD_W'(oh2i(s_rdy[0])), '0);

    // Backpressure: fill, stall, then resume.
    vld  = 3'b000;
    do_reset();
    ordy = 1'b0;
    vld = 3'b001; set_pld(0, 2); step();
    vld = 3'b010; set_pld(1, 3); step();
    vld = 3'b100; set_pld(2, 4); step();
    for (int k = 0; k < 2; k++) cmp("lit_full_rdy", k, REQ_PLD_W'(s_rdy[k]), '0);
    step();
    ordy = 1'b1;
    step();
    for (int k = 0; k < 2; k++) begin
      cmp("lit_pop_no_push", k, REQ_PLD_W'(s_rdy[k]), '0);
      cmp("lit_head_tgt2", k, REQ_PLD_W'(s_pld[k][35:32]), REQ_PLD_W'(2));
    end
    step();
    for (int k = 0; k < 2; k++) begin
      cmp("lit_push_resume", k, REQ_PLD_W'(s_rdy[k]), REQ_PLD_W'(3'b100));
      cmp("lit_head_tgt3", k, REQ_PLD_W'(s_pld[k][35:32]), REQ_PLD_W'(3));
    end
    vld = 3'b000;
    step();
    for (int k = 0; k < 2; k++) cmp("lit_head_tgt4", k, REQ_PLD_W'(s_pld[k][35:32]), REQ_PLD_W'(4));
    step();

    // Reset while the FIFO is full.
    ordy = 1'b0;
    vld  = 3'b111;
    for (int n = 0; n < 3; n++) set_pld(n, 9);
    step();
    step();
    rst = 1'b1;
    step();
    cmp("lit_rst_rdy", 0, REQ_PLD_W'(s_rdy[0]), '0);
    rst  = 1'b0;
    ordy = 1'b1;
    step();
    cmp("lit_post_rst_vld", 0, REQ_PLD_W'(s_ovld[0]), '0);
    cmp("lit_post_rst_in0", 0, REQ_PLD_W'(s_rdy[0]), REQ_PLD_W'(3'b001));
    step();
    step();

    // Random traffic with random downstream ready.
    for (int i = 0; i < 400; i++) begin
      vld  = 3'($urandom_range(0, 7));
      ordy = 1'($urandom_range(0, 3) != 0);
      for (int n = 0; n < 3; n++) set_pld(n, $urandom_range(0, 15));
      step();
    end
    vld  = 3'b000;
    ordy = 1'b1;
    step();
    step();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
